// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and 4-bit function codes.
// Imported by the ALU and by the decoder that drives af.
package alu_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract with carry-out and signed overflow.
// Ports: a, b operands; sub selects a-b; sum, carry, ovf results.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  // Subtract as a + ~b + 1; carry=1 then means no borrow (a >= b unsigned).
  assign bx    = b ^ {WIDTH{sub}};
  assign full  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sum   = full[WIDTH-1:0];
  assign carry = full[WIDTH];
  // Overflow: operands (after inversion) agree in sign, result differs.
  assign ovf   = (a[WIDTH-1] == bx[WIDTH-1]) &&
                 (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Single-cycle registered integer ALU (R-type and I-type ops).
// Ports: clk, rst_n, i, SrcA, SrcB, af in; Alures, Zero, Neg, ovfalu out.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       af,
  output logic [WIDTH-1:0] Alures,
  output logic             Zero,
  output logic             Neg,
  output logic             ovfalu
);

  localparam int SHW = $clog2(WIDTH);

  logic             sub_en;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             as_ovf;
  logic             lt_s;
  logic             lt_u;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             ovf;

  // Immediate form of SUB has no encoding; it runs as ADD.
  assign sub_en = ((af == ALU_SUB) && !i) ||
                  (af == ALU_SLT) || (af == ALU_SLTU);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (SrcA),
    .b     (SrcB),
    .sub   (sub_en),
    .sum   (sum),
    .carry (carry),
    .ovf   (as_ovf)
  );

  assign lt_s  = sum[WIDTH-1] ^ as_ovf;
  assign lt_u  = ~carry;
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (af)
      ALU_ADD, ALU_SUB: begin
        res = sum;
        ovf = as_ovf;
      end
      ALU_SLL:   res = SrcA << shamt;
      ALU_SLT:   res = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_XOR:   res = SrcA ^ SrcB;
      ALU_SRL:   res = SrcA >> shamt;
      ALU_SRA:   res = $unsigned($signed(SrcA) >>> shamt);
      ALU_AND:   res = SrcA & SrcB;
      ALU_OR:    res = SrcA | SrcB;
      ALU_NOR:   res = ~(SrcA | SrcB);
      ALU_PASSB: res = SrcB;
      default: begin
        res = '0;
        ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Alures <= '0;
      Zero   <= 1'b1;
      Neg    <= 1'b0;
      ovfalu <= 1'b0;
    end else begin
      Alures <= res;
      Zero   <= (res == '0);
      Neg    <= res[WIDTH-1];
      ovfalu <= ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed ops push expected results,
// a monitor pops and compares one cycle after each sampling edge.
module tb_alu;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        neg;
    logic        ovf;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  af;
  logic [31:0] Alures;
  logic        Zero;
  logic        Neg;
  logic        ovfalu;

  logic        vld;
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          done  = 1'b0;

  always #5 clk = ~clk;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .af     (af),
    .Alures (Alures),
    .Zero   (Zero),
    .Neg    (Neg),
    .ovfalu (ovfalu)
  );

  // Drive one op at the negedge; it is sampled at the next posedge.
  task automatic issue(input string nm, input logic rn,
                       input logic ii, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic ov);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    i     = ii;
    af    = f;
    SrcA  = a;
    SrcB  = b;
    vld   = 1'b1;
    e.name = nm;
    if (!rn) begin
      e.res  = 32'h0;
      e.zero = 1'b1;
      e.neg  = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      e.res  = r;
      e.zero = (r == 32'h0);
      e.neg  = r[31];
      e.ovf  = ov;
    end
    sb.push_back(e);
  endtask

  // Monitor: an edge that sampled a valid op owes one result.
  initial begin : monitor
    exp_t e;
    logic v;
    while (!done) begin
      @(posedge clk);
      v = vld;
      #1;
      if (v) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL underflow: result with empty scoreboard");
        end else begin
          e = sb.pop_front();
          if (Alures !== e.res || Zero !== e.zero ||
              Neg !== e.neg || ovfalu !== e.ovf) begin
            n_bad++;
            $display("FAIL %s: got res=%h z=%b n=%b v=%b want res=%h z=%b n=%b v=%b",
                     e.name, Alures, Zero, Neg, ovfalu,
                     e.res, e.zero, e.neg, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i     = 1'b0;
    af    = 4'h0;
    SrcA  = 32'h0;
    SrcB  = 32'h0;
    vld   = 1'b0;

    // reset state with junk operands
    issue("rst0", 0, 0, 4'h0, 32'h1234, 32'h1, 0, 0);
    issue("rst1", 0, 0, 4'h0, 32'h7fff_ffff, 32'h1, 0, 0);

    issue("addi",   1, 1, 4'h0, 32'd10, 32'd5, 32'd15, 0);
    issue("and",    1, 0, 4'h8, 32'd12, 32'd8, 32'd8, 0);
    issue("srli",   1, 1, 4'h6, 32'd20, 32'd2, 32'd5, 0);
    issue("addovf", 1, 0, 4'h0, 32'h7fff_ffff, 32'h1, 32'h8000_0000, 1);
    issue("sub0",   1, 0, 4'h1, 32'd5, 32'd5, 32'h0, 0);
    issue("subi",   1, 1, 4'h1, 32'd7, 32'd3, 32'd10, 0);
    issue("subr",   1, 0, 4'h1, 32'd7, 32'd3, 32'd4, 0);
    issue("subovf", 1, 0, 4'h1, 32'h8000_0000, 32'h1, 32'h7fff_ffff, 1);
    issue("subovf2",1, 0, 4'h1, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 1);
    issue("addwrap",1, 0, 4'h0, 32'hffff_ffff, 32'h1, 32'h0, 0);
    issue("slt",    1, 0, 4'h3, 32'hffff_ffff, 32'h0, 32'h1, 0);
    issue("sltu",   1, 0, 4'h4, 32'hffff_ffff, 32'h0, 32'h0, 0);
    issue("slt2",   1, 0, 4'h3, 32'h1, 32'hffff_ffff, 32'h0, 0);
    issue("sltu2",  1, 0, 4'h4, 32'h1, 32'hffff_ffff, 32'h1, 0);
    issue("sra",    1, 0, 4'h7, 32'h8000_0000, 32'd31, 32'hffff_ffff, 0);
    issue("sll",    1, 0, 4'h2, 32'h1, 32'h24, 32'h10, 0);
    issue("srl0",   1, 0, 4'h6, 32'hdead_beef, 32'h20, 32'hdead_beef, 0);
    issue("srl",    1, 0, 4'h6, 32'h8000_0000, 32'd31, 32'h1, 0);
    issue("xor",    1, 0, 4'h5, 32'hf0f0_f0f0, 32'hff00_ff00, 32'h0ff0_0ff0, 0);
    issue("or",     1, 0, 4'h9, 32'h0f, 32'hf0, 32'hff, 0);
    issue("nor",    1, 0, 4'ha, 32'h0, 32'h0, 32'hffff_ffff, 0);
    issue("passb",  1, 1, 4'hb, 32'h5555, 32'h1234_5000, 32'h1234_5000, 0);
    issue("rsvc",   1, 0, 4'hc, 32'h1, 32'h1, 32'h0, 0);
    issue("rsvf",   1, 0, 4'hf, 32'h7fff_ffff, 32'h1, 32'h0, 0);

    // reset mid-stream, then back-to-back ops
    issue("pre",    1, 0, 4'h0, 32'd1, 32'd2, 32'd3, 0);
    issue("mrst0",  0, 0, 4'h0, 32'd100, 32'd1, 0, 0);
    issue("mrst1",  0, 0, 4'h9, 32'hffff, 32'h1, 0, 0);
    issue("post0",  1, 0, 4'h0, 32'd100, 32'd1, 32'd101, 0);
    issue("post1",  1, 0, 4'h1, 32'd100, 32'd1, 32'd99, 0);
    issue("post2",  1, 0, 4'ha, 32'h0, 32'hffff_0000, 32'h0000_ffff, 0);

    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results pending, want 0", sb.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
